// File: rtl/dma_pkg.sv
// Shared types for the data-memory block-transfer initiator.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dat_mem.sv
// Single-port data memory: combinational read gated by rd_en, synchronous write.
module dat_mem #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic [DW-1:0] dat_in,
    output logic [DW-1:0] dat_out
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= dat_in;
    end

    assign dat_out = rd_en ? mem[addr] : '0;

endmodule

// File: rtl/dat_mem_dma.sv
// Copy/fill block-transfer initiator driving the data memory port.
module dat_mem_dma
    import dma_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    dma_state_t    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            fill_q  <= '0;
            mode_q  <= MODE_COPY;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs are held low while reset is high so a write in flight at the
    // reset edge never lands in memory.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        mode_d    = mode_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_d  = src_addr;
                        dst_d  = dst_addr;
                        cnt_d  = len;
                        fill_d = fill_val;
                        mode_d = mode;
                        if (len == '0)             state_d = DONE;
                        else if (mode == MODE_FILL) state_d = WR;
                        else                        state_d = RD;
                    end
                end
                RD: begin
                    busy      = 1'b1;
                    mem_addr  = src_q;
                    mem_rd_en = 1'b1;
                    buf_d     = mem_rdata;
                    state_d   = WR;
                end
                WR: begin
                    busy      = 1'b1;
                    mem_addr  = dst_q;
                    mem_wr_en = 1'b1;
                    mem_wdata = (mode_q == MODE_COPY) ? buf_q : fill_q;
                    src_d     = src_q + AW'(1);
                    dst_d     = dst_q + AW'(1);
                    cnt_d     = cnt_q - AW'(1);
                    if (cnt_q == AW'(1))        state_d = DONE;
                    else if (mode_q == MODE_COPY) state_d = RD;
                    else                          state_d = WR;
                end
                DONE: begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dat_mem_dma.sv
// Bench for dat_mem_dma: vector table of transfers plus hand-written corner sequences.
module tb_dat_mem_dma;

    logic       clk = 1'b0;
    logic       reset, start, mode;
    logic [7:0] src_addr, dst_addr, len, fill_val;
    logic       busy, done, mem_rd_en, mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    // host-side memory port, muxed in while the DMA is not busy
    logic [7:0] tb_addr, tb_wdata;
    logic       tb_rd, tb_wr;
    logic [7:0] m_addr, m_wdata;
    logic       m_rd, m_wr;

    assign m_addr  = busy ? mem_addr  : tb_addr;
    assign m_wdata = busy ? mem_wdata : tb_wdata;
    assign m_rd    = busy ? mem_rd_en : tb_rd;
    assign m_wr    = busy ? mem_wr_en : tb_wr;

    always #5 clk = ~clk;

    dat_mem #(.AW(8), .DW(8)) u_mem (
        .clk(clk), .addr(m_addr), .rd_en(m_rd), .wr_en(m_wr),
        .dat_in(m_wdata), .dat_out(mem_rdata)
    );

    dat_mem_dma #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_chk = 0, n_pass = 0;
    int done_cnt = 0, rd_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  model [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // scoreboard: every DMA write must match the next expected {addr,data}
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_rd_en) rd_cnt++;
        if (mem_rd_en && mem_wr_en) begin
            n_chk++;
            $display("FAIL rd_wr_overlap: got rd=1 wr=1 want not both");
        end
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got addr %0h data %0h want none", mem_addr, mem_wdata);
            end else begin
                check("write", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic mem_write(input logic [7:0] a, input logic [7:0] v);
        tb_addr = a; tb_wdata = v; tb_wr = 1'b1;
        @(posedge clk); #1;
        tb_wr = 1'b0;
        model[a] = v;
    endtask

    task automatic read_mem(input logic [7:0] a, output logic [7:0] v);
        tb_addr = a; tb_rd = 1'b1;
        #1 v = mem_rdata;
        tb_rd = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int errs = 0;
        logic [7:0] v;
        for (int a = 0; a < 256; a++) begin
            read_mem(8'(a), v);
            if (v !== model[a]) errs++;
        end
        check(name, errs, 0);
        @(posedge clk); #1;
    endtask

    // reference: forward byte-by-byte transfer over the shadow memory
    task automatic expect_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [7:0] l, input logic [7:0] f);
        logic [7:0] as, ad, v;
        for (int i = 0; i < int'(l); i++) begin
            as = s + 8'(i);
            ad = d + 8'(i);
            v  = m ? f : model[as];
            model[ad] = v;
            exp_q.push_back({ad, v});
        end
    endtask

    task automatic run_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] f,
                            output int lat, output int bcyc);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m; src_addr = ~s; dst_addr = ~d; len = 8'hFF; fill_val = ~f;
        lat = 0; bcyc = 0;
        for (int n = 1; n <= 600; n++) begin
            if (busy) bcyc++;
            if (done) begin lat = n; break; end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        string      name;
        logic       m;
        logic [7:0] s, d, l, f;
        int         lat;
        int         rds;
    } vec_t;

    vec_t tv[6];

    initial begin
        int lat, bcyc;
        logic [7:0] v;

        tv[0] = '{"copy_basic",   1'b0, 8'd10,  8'd40,  8'd4, 8'h00, 9, 4};
        tv[1] = '{"fill_wrap",    1'b1, 8'h00,  8'hFE,  8'd4, 8'h5A, 5, 0};
        tv[2] = '{"len_zero",     1'b0, 8'd5,   8'd6,   8'd0, 8'h00, 1, 0};
        tv[3] = '{"overlap",      1'b0, 8'd20,  8'd21,  8'd3, 8'h00, 7, 3};
        tv[4] = '{"copy_srcwrap", 1'b0, 8'hFE,  8'd30,  8'd3, 8'h00, 7, 3};
        tv[5] = '{"fill_one",     1'b1, 8'h00,  8'd70,  8'd1, 8'hC3, 2, 0};

        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
        tb_addr = '0; tb_wdata = '0; tb_rd = 1'b0; tb_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", {busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 0);

        for (int i = 0; i < 256; i++) mem_write(8'(i), 8'(i * 37 + 5));
        mem_write(8'd10, 8'hA1); mem_write(8'd11, 8'hA2);
        mem_write(8'd12, 8'hA3); mem_write(8'd13, 8'hA4);
        mem_write(8'd20, 8'h11); mem_write(8'd21, 8'h22);

        foreach (tv[i]) begin
            rd_cnt = 0; done_cnt = 0;
            expect_xfer(tv[i].m, tv[i].s, tv[i].d, tv[i].l, tv[i].f);
            run_xfer(tv[i].m, tv[i].s, tv[i].d, tv[i].l, tv[i].f, lat, bcyc);
            check({tv[i].name, "_latency"}, lat, tv[i].lat);
            check({tv[i].name, "_busy_cycles"}, bcyc, tv[i].lat);
            @(posedge clk); #1;
            check({tv[i].name, "_done_busy_clear"}, {busy, done}, 0);
            check({tv[i].name, "_reads"}, rd_cnt, tv[i].rds);
            check({tv[i].name, "_done_pulses"}, done_cnt, 1);
            check({tv[i].name, "_pending_writes"}, exp_q.size(), 0);
            check_mem({tv[i].name, "_memory"});
        end

        read_mem(8'd21, v); check("overlap_21", v, 8'h11);
        read_mem(8'd23, v); check("overlap_23", v, 8'h11);
        read_mem(8'd1, v);  check("fill_wrap_01", v, 8'h5A);
        read_mem(8'd43, v); check("copy_basic_43", v, 8'hA4);
        @(posedge clk); #1;

        // start while busy is dropped, and so is start in the DONE cycle
        done_cnt = 0;
        expect_xfer(1'b0, 8'd50, 8'd60, 8'd3, 8'h00);
        mode = 1'b0; src_addr = 8'd50; dst_addr = 8'd60; len = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mode = 1'b1; dst_addr = 8'd90; len = 8'd5; fill_val = 8'hEE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            if (done) begin lat = 1; break; end
            @(posedge clk); #1;
        end
        check("busy_start_done_seen", lat, 1);
        mode = 1'b1; dst_addr = 8'd91; len = 8'd1; fill_val = 8'hEE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_ignored", busy, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_done_pulses", done_cnt, 1);
        check("busy_start_pending", exp_q.size(), 0);
        check_mem("busy_start_memory");

        // reset during the third write of a 6-byte copy
        done_cnt = 0;
        expect_xfer(1'b0, 8'd100, 8'd120, 8'd2, 8'h00);
        mode = 1'b0; src_addr = 8'd100; dst_addr = 8'd120; len = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_in_wr", {busy, mem_wr_en, mem_addr}, {1'b1, 1'b1, 8'd122});
        reset = 1'b1;
        #1;
        check("reset_gates_write", mem_wr_en, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("after_reset_outputs", {busy, done, mem_rd_en, mem_wr_en}, 0);
        repeat (4) @(posedge clk);
        #1;
        check("after_reset_no_done", done_cnt, 0);
        check("after_reset_pending", exp_q.size(), 0);
        check_mem("after_reset_memory");

        done_cnt = 0;
        expect_xfer(1'b0, 8'd100, 8'd120, 8'd6, 8'h00);
        run_xfer(1'b0, 8'd100, 8'd120, 8'd6, 8'h00, lat, bcyc);
        check("rerun_latency", lat, 13);
        @(posedge clk); #1;
        check("rerun_done_pulses", done_cnt, 1);
        check("rerun_pending", exp_q.size(), 0);
        check_mem("rerun_memory");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dat_mem_dma.md
Name: dat_mem_dma

Overview:
Block-transfer initiator that drives the single-port 256x8 data memory: the requesting side of its addr/rd_en/wr_en/dat_in/dat_out interface.
- Copy mode: moves a run of bytes from a source address range to a destination address range.
- Fill mode: writes a constant byte over a destination range.
- Sits between the processor control path (start/args) and data memory. The processor holds off its own memory accesses while busy=1; a mux upstream of data memory selects the DMA when busy.

Parameters:
AW, 8, address width; memory depth is 2**AW.
DW, 8, data width.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
mode  in  1  0=copy, 1=fill.
src_addr  in  AW  copy source base.
dst_addr  in  AW  destination base.
len  in  AW  byte count; 0 = no transfer.
fill_val  in  DW  fill byte.
busy  out  1  high from the cycle after accepted start through the DONE cycle.
done  out  1  one-cycle pulse at completion.
mem_addr  out  AW  drives memory addr.
mem_rd_en  out  1  drives memory rd_en.
mem_wr_en  out  1  drives memory wr_en.
mem_wdata  out  DW  drives memory dat_in.
mem_rdata  in  DW  from memory dat_out; combinational read, valid in the same cycle as mem_addr/mem_rd_en.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset: state=IDLE; all outputs 0; internal src/dst/count/buffer registers cleared.
- IDLE:
  - On start=1, capture src_addr, dst_addr, len, mode and fill_val into registers. Later input changes have no effect.
  - len=0 -> DONE.
  - mode=0 -> RD.
  - mode=1 -> WR.
  - start=0 -> stay in IDLE.
- RD (copy only):
  - Drive mem_addr=src_reg, mem_rd_en=1.
  - At the clock edge, latch mem_rdata into buf and go to WR.
- WR:
  - Drive mem_addr=dst_reg, mem_wr_en=1, mem_wdata = buf in copy mode or fill_reg in fill mode.
  - At the clock edge: src_reg++, dst_reg++, count--.
  - If count was 1 -> DONE; else copy -> RD, fill -> WR.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Outputs in IDLE: mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0.
- Outside their active state, mem_rd_en and mem_wr_en are 0. The two are never high together.
- Latency from the start cycle to the done cycle:
  - copy: 2*len+1 cycles;
  - fill: len+1 cycles;
  - len=0: 1 cycle.
- Address arithmetic is modulo 2**AW. 8'hFF+1 wraps to 8'h00 for both src and dst.
- Overlap: copy is strictly forward, byte by byte, and each byte is read after the previous write. If dst = src+k with 0<k<len, the first k bytes replicate; this is defined behaviour.
- start while busy is ignored; it is not queued.
- start asserted in the DONE cycle is ignored. A new start is accepted in IDLE the following cycle.
- reset mid-transfer: the next cycle is IDLE with all outputs 0. A write in progress at that edge does not complete, because mem_wr_en is low after reset. done is not pulsed.
- Count register is AW bits wide; len max is 2**AW-1.

Decomposition:
- Shared package dma_pkg holds:
  - enum dma_state_t {IDLE, RD, WR, DONE};
  - localparams MODE_COPY=1'b0, MODE_FILL=1'b1.
- No sub-module. The FSM, address counters and buffer register live in one module.
- The bench instantiates dat_mem as the memory model, wired to the mem_* ports.

Test Plan:
- Copy basic: preload mem[10..13]=8'hA1,A2,A3,A4; start copy src=10, dst=40, len=4 -> mem[40..43]=A1..A4; done pulses exactly 9 cycles after start; mem[10..13] unchanged.
- Fill with wrap: start fill dst=8'hFE, len=4, fill_val=8'h5A -> mem[FE], mem[FF], mem[00], mem[01] all = 8'h5A; mem[02] untouched; done 5 cycles after start.
- len=0: start copy len=0 -> no mem_wr_en or mem_rd_en ever high; busy=1 for one cycle; done pulses 1 cycle after start.
- Overlap forward: mem[20]=8'h11, mem[21]=8'h22; copy src=20, dst=21, len=3 -> mem[21..23]=8'h11,8'h11,8'h11.
- Start while busy: second start (dst=90) asserted mid-copy -> ignored; mem[90] unchanged; exactly one done pulse.
- Reset mid-operation: assert reset in the 3rd WR cycle of a len=6 copy -> next cycle busy=0, mem_wr_en=0, no done pulse; only the first 2 destination bytes are written. A subsequent start runs a full transfer.
